// File: rtl/note_lane_dropper_if.sv
// Lane bundle between the keyboard/score side and one falling-note engine:
// key codes in, sprite position, bitmap and judgement flags out.
`timescale 1ns/1ps
interface note_lane_dropper_if;
    logic [7:0]    keycode;
    logic [7:0]    keycode_second;
    logic [9:0]    dropX;
    logic [9:0]    dropY;
    logic [1599:0] arrow;
    logic          visible;
    logic          hit_perfect;
    logic          hit_good;
    logic          miss;
    logic          score_pulse;
    logic          busy;

    modport master (
        output keycode, keycode_second,
        input  dropX, dropY, arrow, visible, hit_perfect, hit_good, miss, score_pulse, busy
    );

    modport slave (
        input  keycode, keycode_second,
        output dropX, dropY, arrow, visible, hit_perfect, hit_good, miss, score_pulse, busy
    );
endinterface

// File: rtl/note_lane_dropper.sv
// Single-lane falling note: waits START_DELAY frames after the start key, falls
// toward the judgement line and grades the first fresh lane-key press.
`timescale 1ns/1ps
module note_lane_dropper #(
    parameter logic [9:0]    LANE_X      = 10'd40,
    parameter logic [9:0]    Y_START     = 10'd100,
    parameter logic [9:0]    Y_MAX       = 10'd400,
    parameter logic [9:0]    NOTE_H      = 10'd40,
    parameter logic [11:0]   START_DELAY = 12'd2620,
    parameter logic [3:0]    SPEED       = 4'd1,
    parameter logic [9:0]    HIT_LO      = 10'd340,
    parameter logic [9:0]    PERF_LO     = 10'd360,
    parameter logic [9:0]    PERF_HI     = 10'd380,
    parameter logic [7:0]    KEY_CODE    = 8'h04,
    parameter logic [7:0]    START_KEY   = 8'h2c,
    parameter logic [7:0]    RESTART_KEY = 8'h01,
    parameter logic [1599:0] SPRITE      = {40{40'h00_ff_ff_ff_00}}
) (
    input  logic frame_clk,
    input  logic Reset,
    note_lane_dropper_if.slave lane
);

    typedef enum logic [1:0] {IDLE, WAIT, FALL, DONE} state_t;

    // Highest Y the note may take; a clamped step lands the bottom edge exactly on Y_MAX.
    localparam logic [9:0]  Y_FLOOR   = Y_MAX - NOTE_H;
    localparam logic [11:0] WAIT_LAST = START_DELAY - 12'd1;

    state_t      state_reg;
    logic [9:0]  y_reg;
    logic [11:0] counter_reg;
    logic        key_prev_reg;
    logic        hit_perfect_reg;
    logic        hit_good_reg;
    logic        miss_reg;
    logic        score_pulse_reg;
    logic        visible_reg;

    logic        key_now;
    logic        key_edge;
    logic        start_now;
    logic        restart_now;
    logic [9:0]  bottom;
    logic [10:0] y_sum;
    logic [9:0]  y_step_next;
    logic        in_hit;
    logic        in_perfect;

    always_comb begin
        key_now     = (lane.keycode == KEY_CODE) | (lane.keycode_second == KEY_CODE);
        key_edge    = key_now & ~key_prev_reg;
        start_now   = (lane.keycode == START_KEY);
        restart_now = (lane.keycode == RESTART_KEY);
        bottom      = y_reg + NOTE_H;
        y_sum       = {1'b0, y_reg} + {7'd0, SPEED};
        y_step_next = (y_sum > {1'b0, Y_FLOOR}) ? Y_FLOOR : y_sum[9:0];
        in_hit      = (bottom >= HIT_LO) && (bottom < Y_MAX);
        in_perfect  = (bottom >= PERF_LO) && (bottom < PERF_HI);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IDLE;
            y_reg           <= Y_START;
            counter_reg     <= 12'd0;
            key_prev_reg    <= 1'b0;
            hit_perfect_reg <= 1'b0;
            hit_good_reg    <= 1'b0;
            miss_reg        <= 1'b0;
            score_pulse_reg <= 1'b0;
            visible_reg     <= 1'b0;
        end else begin
            key_prev_reg    <= key_now;
            score_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    y_reg           <= Y_START;
                    counter_reg     <= 12'd0;
                    hit_perfect_reg <= 1'b0;
                    hit_good_reg    <= 1'b0;
                    miss_reg        <= 1'b0;
                    if (start_now) begin
                        state_reg   <= (START_DELAY == 12'd0) ? FALL : WAIT;
                        visible_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (counter_reg == WAIT_LAST) begin
                        state_reg <= FALL;
                    end else begin
                        counter_reg <= counter_reg + 12'd1;
                    end
                end
                FALL: begin
                    // Reaching the line beats a key edge landing on the same frame.
                    if (bottom >= Y_MAX) begin
                        miss_reg    <= 1'b1;
                        state_reg   <= DONE;
                        visible_reg <= 1'b0;
                    end else if (key_edge && in_hit) begin
                        hit_perfect_reg <= in_perfect;
                        hit_good_reg    <= ~in_perfect;
                        score_pulse_reg <= 1'b1;
                        state_reg       <= DONE;
                        visible_reg     <= 1'b0;
                    end else begin
                        y_reg <= y_step_next;
                    end
                end
                DONE: begin
                    if (restart_now) begin
                        state_reg       <= IDLE;
                        y_reg           <= Y_START;
                        hit_perfect_reg <= 1'b0;
                        hit_good_reg    <= 1'b0;
                        miss_reg        <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    visible_reg <= 1'b0;
                end
            endcase
        end
    end

    assign lane.dropX       = LANE_X;
    assign lane.dropY       = y_reg;
    assign lane.visible     = visible_reg;
    assign lane.busy        = visible_reg;
    assign lane.hit_perfect = hit_perfect_reg;
    assign lane.hit_good    = hit_good_reg;
    assign lane.miss        = miss_reg;
    assign lane.score_pulse = score_pulse_reg;

    // Sprite gated row by row so the renderer sees zeros whenever the note is hidden.
    generate
        for (genvar gi = 0; gi < 40; gi++) begin : g_arrow_row
            assign lane.arrow[gi*40 +: 40] = visible_reg ? SPRITE[gi*40 +: 40] : 40'd0;
        end
    endgenerate

endmodule

// File: tb/tb_note_lane_dropper.sv
// Directed bench: table of single-run scenarios on a START_DELAY=4 lane, plus
// hand sequences for reset, key filtering, async reset and a SPEED=7 lane.
`timescale 1ns/1ps
module tb_note_lane_dropper;

    localparam logic [1599:0] SPR = {40{40'hf0_0f_a5_5a_c3}};
    localparam logic [7:0] K_LANE = 8'h04;
    localparam logic [7:0] K_START = 8'h2c;
    localparam logic [7:0] K_RESTART = 8'h01;

    logic frame_clk = 1'b0;
    logic Reset = 1'b1;
    always #5 frame_clk = ~frame_clk;

    note_lane_dropper_if lane_a();
    note_lane_dropper_if lane_b();

    note_lane_dropper #(.START_DELAY(12'd4), .SPRITE(SPR)) dut_a (
        .frame_clk(frame_clk), .Reset(Reset), .lane(lane_a)
    );
    note_lane_dropper #(.START_DELAY(12'd0), .SPEED(4'd7), .SPRITE(SPR)) dut_b (
        .frame_clk(frame_clk), .Reset(Reset), .lane(lane_b)
    );

    typedef struct {
        string name;
        int    press;
        bit    second;
        bit    hold_wait;
        int    hold_until;
        bit    exp_perf;
        bit    exp_good;
        bit    exp_miss;
        int    exp_y;
        int    exp_pulses;
    } vec_t;

    vec_t vecs[12];
    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        lane_a.keycode = 8'h00; lane_a.keycode_second = 8'h00;
        lane_b.keycode = 8'h00; lane_b.keycode_second = 8'h00;
        Reset = 1'b1;
        repeat (2) step();
        Reset = 1'b0;
    endtask

    task automatic drive_a(input bit key, input bit second);
        lane_a.keycode        = (key && !second) ? K_LANE : 8'h00;
        lane_a.keycode_second = (key && second) ? K_LANE : 8'h00;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int pulses;
        bit done;
        bit key;
        do_reset();
        lane_a.keycode = K_START;
        step();
        drive_a(v.hold_wait, v.second);
        repeat (4) step();
        pulses = 0;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            key = (v.hold_wait && k <= v.hold_until) || (k == v.press);
            drive_a(key, v.second);
            step();
            pulses += int'(lane_a.score_pulse);
            if (!lane_a.visible) done = 1'b1;
        end
        check({v.name, "_done"}, int'(done), 1);
        drive_a(1'b0, 1'b0);
        step();
        pulses += int'(lane_a.score_pulse);
        check({v.name, "_perfect"}, int'(lane_a.hit_perfect), int'(v.exp_perf));
        check({v.name, "_good"}, int'(lane_a.hit_good), int'(v.exp_good));
        check({v.name, "_miss"}, int'(lane_a.miss), int'(v.exp_miss));
        check({v.name, "_dropY"}, int'(lane_a.dropY), v.exp_y);
        check({v.name, "_pulses"}, pulses, v.exp_pulses);
        check({v.name, "_arrow_off"}, int'(lane_a.arrow == '0), 1);
        $display("vec %0d %s: perf=%0b good=%0b miss=%0b dropY=%0d pulses=%0d",
                 idx, v.name, lane_a.hit_perfect, lane_a.hit_good, lane_a.miss, lane_a.dropY, pulses);
    endtask

    initial begin
        int y_exp;
        bit ended;
        //        name          press 2nd hold until perf good miss  y   pulses
        vecs[0]  = '{"no_key",     -1, 0, 0,  -1,  0, 0, 1, 360, 0};
        vecs[1]  = '{"perf225_k2", 225, 1, 0,  -1,  1, 0, 0, 325, 1};
        vecs[2]  = '{"good205",    205, 0, 0,  -1,  0, 1, 0, 305, 1};
        vecs[3]  = '{"early190",   190, 0, 0,  -1,  0, 0, 1, 360, 0};
        vecs[4]  = '{"held_all",    -1, 0, 1, 999,  0, 0, 1, 360, 0};
        vecs[5]  = '{"rehit225",   225, 0, 1, 209,  1, 0, 0, 325, 1};
        vecs[6]  = '{"good259",    259, 0, 0,  -1,  0, 1, 0, 359, 1};
        vecs[7]  = '{"miss_prio",  260, 1, 0,  -1,  0, 0, 1, 360, 0};
        vecs[8]  = '{"perf_hi",    240, 0, 0,  -1,  0, 1, 0, 340, 1};
        vecs[9]  = '{"perf_lo",    220, 0, 0,  -1,  1, 0, 0, 320, 1};
        vecs[10] = '{"hit_lo",     200, 1, 0,  -1,  0, 1, 0, 300, 1};
        vecs[11] = '{"below_lo",   199, 0, 0,  -1,  0, 0, 1, 360, 0};

        // Reset state, checked while reset is still asserted.
        lane_a.keycode = 8'h00; lane_a.keycode_second = 8'h00;
        lane_b.keycode = 8'h00; lane_b.keycode_second = 8'h00;
        step(); step();
        check("rst_dropX", int'(lane_a.dropX), 40);
        check("rst_dropY", int'(lane_a.dropY), 100);
        check("rst_visible", int'(lane_a.visible), 0);
        check("rst_busy", int'(lane_a.busy), 0);
        check("rst_flags", int'({lane_a.hit_perfect, lane_a.hit_good, lane_a.miss, lane_a.score_pulse}), 0);
        check("rst_arrow_off", int'(lane_a.arrow == '0), 1);
        $display("reset: dropX=%0d dropY=%0d visible=%0b", lane_a.dropX, lane_a.dropY, lane_a.visible);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // WAIT length, sprite output and stray keys during FALL.
        do_reset();
        step();
        check("idle_no_start", int'(lane_a.busy), 0);
        lane_a.keycode = K_START;
        step();
        lane_a.keycode = 8'h00;
        check("start_busy", int'(lane_a.busy), 1);
        check("start_arrow", int'(lane_a.arrow == SPR), 1);
        repeat (4) step();
        check("wait_hold_y", int'(lane_a.dropY), 100);
        step();
        check("fall_first_y", int'(lane_a.dropY), 101);
        lane_a.keycode = K_START;
        step();
        check("start_in_fall_y", int'(lane_a.dropY), 102);
        lane_a.keycode = K_RESTART;
        step();
        lane_a.keycode = 8'h00;
        check("restart_in_fall_vis", int'(lane_a.visible), 1);
        check("restart_in_fall_y", int'(lane_a.dropY), 103);
        repeat (147) step();
        check("mid_fall_y", int'(lane_a.dropY), 250);
        $display("seq fall: dropY=%0d visible=%0b before async reset", lane_a.dropY, lane_a.visible);

        // Asynchronous reset between edges.
        #3 Reset = 1'b1;
        #1;
        check("async_rst_y", int'(lane_a.dropY), 100);
        check("async_rst_vis", int'(lane_a.visible), 0);
        check("async_rst_busy", int'(lane_a.busy), 0);
        #2 Reset = 1'b0;
        step();
        $display("seq async reset: dropY=%0d busy=%0b", lane_a.dropY, lane_a.busy);

        // DONE behaviour: START ignored, RESTART clears flags.
        lane_a.keycode = K_START;
        step();
        lane_a.keycode = 8'h00;
        ended = 1'b0;
        for (int k = 0; k < 400 && !ended; k++) begin
            step();
            if (!lane_a.visible) ended = 1'b1;
        end
        check("done_reached", int'(ended), 1);
        check("done_miss", int'(lane_a.miss), 1);
        lane_a.keycode = K_START;
        step();
        check("start_in_done_vis", int'(lane_a.visible), 0);
        check("start_in_done_miss", int'(lane_a.miss), 1);
        lane_a.keycode = K_RESTART;
        step();
        lane_a.keycode = 8'h00;
        check("restart_miss_clr", int'(lane_a.miss), 0);
        check("restart_busy", int'(lane_a.busy), 0);
        check("restart_y", int'(lane_a.dropY), 100);
        $display("seq done/restart: miss=%0b busy=%0b dropY=%0d", lane_a.miss, lane_a.busy, lane_a.dropY);

        // SPEED=7 lane with zero start delay: straight to FALL, clamp then miss.
        do_reset();
        lane_b.keycode = K_START;
        step();
        lane_b.keycode = 8'h00;
        check("b_visible", int'(lane_b.visible), 1);
        check("b_start_y", int'(lane_b.dropY), 100);
        y_exp = 100;
        ended = 1'b0;
        for (int k = 0; k < 100 && !ended; k++) begin
            step();
            if (y_exp + 40 >= 400) begin
                ended = 1'b1;
            end else begin
                y_exp = (y_exp + 7 > 360) ? 360 : y_exp + 7;
                check("b_step_y", int'(lane_b.dropY), y_exp);
                $display("speed7 frame %0d: dropY=%0d", k, lane_b.dropY);
            end
        end
        check("b_miss", int'(lane_b.miss), 1);
        check("b_final_y", int'(lane_b.dropY), 360);
        check("b_hidden", int'(lane_b.visible), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
